multi_tone_sound_generator: RTL and testbench
=============================================

Name: multi_tone_sound_generator

Overview:
Parametrised successor to the single-tone game sound generator. Accepts NUM_EVT prioritised game-event requests (good collision, bad collision, direction change, game over, ...) with per-event runtime pitch and duration, a mute toggle and a selectable waveform. Produces a DAC_W-bit sample for the on-board DAC. Sits between game logic and the DAC output pins.

Parameters:
DAC_W, 8, width of the DAC sample output
NUM_EVT, 4, number of event channels; index 0 has the highest priority
DIV_W, 16, width of the per-event tone divider
DUR_W, 24, width of the per-event duration count in clk cycles

Ports:
clk  in  1  system clock
nRst  in  1  asynchronous active-low reset
button_i  in  1  mute toggle request; level input, rising edge acts
evt_i  in  NUM_EVT  event request levels; rising edge triggers a note
tone_div_i  in  NUM_EVT*DIV_W  per-event clk cycles per phase step; slice i = [i*DIV_W +: DIV_W]
tone_dur_i  in  NUM_EVT*DUR_W  per-event note length in clk cycles
wave_i  in  2  waveform select: 00 square, 01 sawtooth, 10 triangle, 11 silent
dacCount  out  DAC_W  DAC sample
busy_o  out  1  a note is playing
active_evt_o  out  $clog2(NUM_EVT)  index of the playing event; 0 when idle
muted_o  out  1  mute state

Behaviour:
- One clock. Reset is asynchronous and active-low. Clock port is clk; reset port is nRst.
- Reset values: dacCount=0, busy_o=0, active_evt_o=0, muted_o=0, state=IDLE, all counters 0, edge-detect registers 0.
- Edge detect: evt_i and button_i are registered each cycle. A trigger is cur & ~prev. A level held high fires once.
- Mute: each button rising edge toggles muted_o. The toggle takes effect on the same edge the rise is sampled.
  - Muted to 1: any playing note aborts, state goes to IDLE, dacCount is 0 from the next cycle.
  - While muted, all event triggers are ignored. Events are not queued.
- FSM states IDLE and PLAY:
  - IDLE -> PLAY on a trigger of event i when unmuted and tone_dur_i[i] != 0.
  - On entry: load dur_cnt=dur-1, div_cnt=0, phase=0, active_evt_o=i, busy_o=1.
  - PLAY: dur_cnt decrements each cycle. Reaching 0 -> IDLE, busy_o=0, active_evt_o=0.
  - PLAY with a trigger on index j <= active: retrigger. Reload as on entry with event j. This preempts or restarts the note.
  - PLAY with a trigger on index j > active: ignored.
- Simultaneous triggers: the lowest index wins and the rest are dropped. A simultaneous mute toggle to muted wins over any trigger. An event with dur=0 is ignored.
- Oscillator (PLAY only):
  - div_cnt counts 0..max(div,1)-1. div=0 is treated as 1.
  - On wrap, phase (DAC_W bits) increments modulo 2^DAC_W.
  - The divider value is sampled live from the active slice.
- Waveform from phase p with MSB m:
  - square: m ? 0 : {DAC_W{1}}
  - sawtooth: p
  - triangle: m ? ~(p<<1) : (p<<1), truncated to DAC_W
  - silent: 0
- dacCount is registered, so it lags phase and state by one cycle. It is 0 in IDLE, and 0 the cycle after PLAY ends.
- Latency: trigger sampled at edge k -> PLAY from edge k -> first nonzero square sample on dacCount after edge k+1.
- Reset mid-note: immediate return to reset values, with no residual sample.

Decomposition:
- Package sound_pkg:
  - wave_t enum (WAVE_SQUARE, WAVE_SAW, WAVE_TRI, WAVE_OFF)
  - state_t enum (IDLE, PLAY)
  - default parameter constants
- Sub-module tone_osc: divider counter, phase accumulator and wave shaping.
  - Inputs: clk, nRst, en, restart, div, wave.
  - Output: unregistered sample.
- The top level holds edge detect, mute, priority arbiter, FSM, duration counter and the output register.

Test Plan:
All cases use DAC_W=8, NUM_EVT=3, div={2,3,4}, dur={20,40,60}, wave=square unless stated.
1. Reset held mid-note (evt_i[1] raised then nRst=0) -> dacCount=0, busy_o=0, muted_o=0 asynchronously, before the next clk edge.
2. Pulse evt_i[2] -> busy_o=1, active_evt_o=2 for exactly 60 cycles.
   - dacCount=255 for 512 cycles, then 0 (phase MSB toggles every 128 steps x4); truncated at 60 → dacCount=255 throughout.
   - Repeat with dur=1100 and observe a 255->0 transition at cycle 513±1.
3. Sawtooth, div=2 on evt 0, dur=20 -> dacCount sequence 0,0,1,1,2,2,... then 0 after 20 cycles.
4. Priority:
   - evt 1 playing, trigger evt 2 -> ignored, active_evt_o stays 1.
   - Trigger evt 0 -> active_evt_o=0 and dur reloaded to 20.
   - evt_i=3'b111 from idle -> active_evt_o=0.
5. Mute:
   - One button pulse mid-note -> muted_o=1, busy_o=0, dacCount=0 next cycle.
   - Events while muted -> no busy_o.
   - Second pulse -> muted_o=0; the next event plays.
6. Edge cases:
   - dur=0 -> event ignored.
   - div=0 -> behaves as div=1 (saw increments every cycle).
   - Held evt level -> single note only.
   - Triangle phase wrap at 255->0 -> output continuous, with no glitch above 254.

Source files
------------

// File: rtl/multi_tone_sound_generator_pkg.sv
// Purpose: shared types and default sizes for the multi-tone sound generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sound_pkg;

   typedef enum logic [1:0] {
      WAVE_SQUARE = 2'b00,
      WAVE_SAW    = 2'b01,
      WAVE_TRI    = 2'b10,
      WAVE_OFF    = 2'b11
   } wave_t;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   localparam int DEF_DAC_W   = 8;
   localparam int DEF_NUM_EVT = 4;
   localparam int DEF_DIV_W   = 16;
   localparam int DEF_DUR_W   = 24;

endpackage

// File: rtl/multi_tone_sound_generator_if.sv
// Purpose: request bus from game logic: event levels, per-event pitch/duration, wave select, mute button.
// Latency: wires only.
// Backpressure: none; levels are sampled every cycle and edges act immediately.
interface multi_tone_sound_generator_if #(
   parameter int NUM_EVT = 4,
   parameter int DIV_W   = 16,
   parameter int DUR_W   = 24
);
   logic                     button_i;
   logic [NUM_EVT-1:0]       evt_i;
   logic [NUM_EVT*DIV_W-1:0] tone_div_i;
   logic [NUM_EVT*DUR_W-1:0] tone_dur_i;
   logic [1:0]               wave_i;

   modport master (
      output button_i, evt_i, tone_div_i, tone_dur_i, wave_i
   );

   modport slave (
      input button_i, evt_i, tone_div_i, tone_dur_i, wave_i
   );
endinterface

// File: rtl/multi_tone_sound_generator_osc.sv
// Purpose: tone oscillator: clock divider, phase accumulator and waveform shaping.
// Latency: sample is combinational from the phase register (phase advances one edge after a divider wrap).
// Backpressure: none; restart or disable clears divider and phase.
module tone_osc
   import sound_pkg::*;
#(
   parameter int DAC_W = 8,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             en,
   input  logic             restart,
   input  logic [DIV_W-1:0] div,
   input  wave_t            wave,
   output logic [DAC_W-1:0] sample
);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_last;
   logic [DAC_W-1:0] phase;
   logic [DAC_W-1:0] tri_ramp;
   logic             wrap;

   // A divide of zero behaves as one; >= keeps wrapping sane if div shrinks mid-count.
   assign div_last = (div == '0) ? '0 : div - DIV_W'(1);
   assign wrap     = (div_cnt >= div_last);
   assign tri_ramp = {phase[DAC_W-2:0], 1'b0};

   // Divider and phase accumulator; held at zero unless a note is running.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         div_cnt <= '0;
         phase   <= '0;
      end else if (restart || !en) begin
         div_cnt <= '0;
         phase   <= '0;
      end else if (wrap) begin
         div_cnt <= '0;
         phase   <= phase + DAC_W'(1);
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Waveform shaping from the phase; triangle folds the doubled ramp on the MSB.
   always_comb begin
      sample = '0;
      case (wave)
         WAVE_SQUARE: sample = phase[DAC_W-1] ? '0 : '1;
         WAVE_SAW:    sample = phase;
         WAVE_TRI:    sample = phase[DAC_W-1] ? ~tri_ramp : tri_ramp;
         default:     sample = '0;
      endcase
   end

endmodule

// File: rtl/multi_tone_sound_generator.sv
// Purpose: prioritised multi-event tone generator with mute toggle, driving a DAC sample.
// Latency: trigger edge k enters PLAY at k; first sample appears on dacCount after edge k+1.
// Backpressure: none; lower-priority triggers during a note and all triggers while muted are dropped.
module multi_tone_sound_generator
   import sound_pkg::*;
#(
   parameter int DAC_W   = DEF_DAC_W,
   parameter int NUM_EVT = DEF_NUM_EVT,
   parameter int DIV_W   = DEF_DIV_W,
   parameter int DUR_W   = DEF_DUR_W
) (
   input  logic                       clk,
   input  logic                       nRst,
   multi_tone_sound_generator_if.slave req,
   output logic [DAC_W-1:0]           dacCount,
   output logic                       busy_o,
   output logic [$clog2(NUM_EVT)-1:0] active_evt_o,
   output logic                       muted_o
);

   localparam int IDX_W = $clog2(NUM_EVT);

   logic [NUM_EVT-1:0] evt_prev;
   logic               btn_prev;
   logic               muted;
   logic               muted_nxt;
   logic               btn_rise;
   logic [NUM_EVT-1:0] trig;

   logic               win_vld;
   logic [IDX_W-1:0]   win_idx;
   logic [DUR_W-1:0]   win_dur;
   logic               accept;

   state_t             state, state_nxt;
   logic [DUR_W-1:0]   dur_cnt, dur_cnt_nxt;
   logic [IDX_W-1:0]   active_evt, active_nxt;
   logic               restart;

   logic [DIV_W-1:0]   active_div;
   logic [DAC_W-1:0]   sample;

   assign btn_rise  = req.button_i & ~btn_prev;
   assign muted_nxt = muted ^ btn_rise;
   assign trig      = req.evt_i & ~evt_prev;
   // A trigger coinciding with a toggle into mute is lost, as are all triggers while muted.
   assign accept    = win_vld & ~muted_nxt;

   // Edge-detect history and mute state.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         evt_prev <= '0;
         btn_prev <= 1'b0;
         muted    <= 1'b0;
      end else begin
         evt_prev <= req.evt_i;
         btn_prev <= req.button_i;
         muted    <= muted_nxt;
      end
   end

   // Priority arbiter: lowest-index trigger with a nonzero duration wins.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      win_dur = '0;
      for (int i = NUM_EVT - 1; i >= 0; i--) begin
         if (trig[i] && (req.tone_dur_i[i*DUR_W +: DUR_W] != '0)) begin
            win_vld = 1'b1;
            win_idx = IDX_W'(i);
            win_dur = req.tone_dur_i[i*DUR_W +: DUR_W];
         end
      end
   end

   // FSM state, duration counter and active index registers.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state      <= IDLE;
         dur_cnt    <= '0;
         active_evt <= '0;
      end else begin
         state      <= state_nxt;
         dur_cnt    <= dur_cnt_nxt;
         active_evt <= active_nxt;
      end
   end

   // FSM next state: start, retrigger/preempt, mute abort and note expiry.
   always_comb begin
      state_nxt   = state;
      dur_cnt_nxt = dur_cnt;
      active_nxt  = active_evt;
      restart     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt   = PLAY;
               dur_cnt_nxt = win_dur - DUR_W'(1);
               active_nxt  = win_idx;
               restart     = 1'b1;
            end
         end
         PLAY: begin
            if (muted_nxt) begin
               state_nxt   = IDLE;
               dur_cnt_nxt = '0;
               active_nxt  = '0;
            end else if (accept && (win_idx <= active_evt)) begin
               dur_cnt_nxt = win_dur - DUR_W'(1);
               active_nxt  = win_idx;
               restart     = 1'b1;
            end else if (dur_cnt == '0) begin
               state_nxt   = IDLE;
               active_nxt  = '0;
            end else begin
               dur_cnt_nxt = dur_cnt - DUR_W'(1);
            end
         end
         default: begin
            state_nxt   = IDLE;
            dur_cnt_nxt = '0;
            active_nxt  = '0;
         end
      endcase
   end

   // Pitch follows the live divider of whichever event is playing.
   assign active_div = req.tone_div_i[int'(active_evt)*DIV_W +: DIV_W];

   tone_osc #(
      .DAC_W (DAC_W),
      .DIV_W (DIV_W)
   ) u_osc (
      .clk     (clk),
      .nRst    (nRst),
      .en      (state_nxt == PLAY),
      .restart (restart),
      .div     (active_div),
      .wave    (wave_t'(req.wave_i)),
      .sample  (sample)
   );

   // Output sample register: one cycle behind the phase/state it reflects.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         dacCount <= '0;
      end else begin
         dacCount <= (state == PLAY) ? sample : '0;
      end
   end

   assign busy_o       = (state == PLAY);
   assign active_evt_o = active_evt;
   assign muted_o      = muted;

endmodule

// File: tb/tb_multi_tone_sound_generator.sv
// Purpose: directed self-checking bench for multi_tone_sound_generator (DAC_W=8, NUM_EVT=3).
// Latency: inputs driven 1ns after a rising edge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_multi_tone_sound_generator;
   import sound_pkg::*;

   logic       tb_clk;
   logic       nRst;
   logic [7:0] dacCount;
   logic       busy_o;
   logic [1:0] active_evt_o;
   logic       muted_o;
   int         errors;
   int         checks;

   multi_tone_sound_generator_if #(.NUM_EVT(3), .DIV_W(16), .DUR_W(24)) req_if ();

   multi_tone_sound_generator #(
      .DAC_W   (8),
      .NUM_EVT (3),
      .DIV_W   (16),
      .DUR_W   (24)
   ) dut (
      .clk          (tb_clk),
      .nRst         (nRst),
      .req          (req_if.slave),
      .dacCount     (dacCount),
      .busy_o       (busy_o),
      .active_evt_o (active_evt_o),
      .muted_o      (muted_o)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge tb_clk);
         #1;
      end
   endtask

   task automatic set_cfg(input logic [15:0] d0, d1, d2, input logic [23:0] u0, u1, u2,
                          input logic [1:0] w);
      req_if.tone_div_i = {d2, d1, d0};
      req_if.tone_dur_i = {u2, u1, u0};
      req_if.wave_i     = w;
   endtask

   task automatic do_reset();
      req_if.evt_i    = '0;
      req_if.button_i = 1'b0;
      nRst = 1'b0;
      tick(2);
      nRst = 1'b1;
      tick(1);
   endtask

   task automatic pulse_evt(input logic [2:0] m);
      req_if.evt_i = m;
      tick(1);
      req_if.evt_i = '0;
   endtask

   task automatic pulse_btn();
      req_if.button_i = 1'b1;
      tick(1);
      req_if.button_i = 1'b0;
   endtask

   // Counts busy cycles starting at the current one; bounded.
   task automatic busy_len(output int len);
      len = 0;
      while (busy_o && len < 200) begin
         len++;
         tick(1);
      end
   endtask

   task automatic test_reset();
      req_if.evt_i    = '0;
      req_if.button_i = 1'b0;
      set_cfg(16'd2, 16'd3, 16'd4, 24'd20, 24'd40, 24'd60, WAVE_SQUARE);
      nRst = 1'b0;
      tick(2);
      checks++;
      if ({dacCount, busy_o, active_evt_o, muted_o} !== 12'h000) begin
         errors++;
         $display("FAIL reset_state: dac=%0d busy=%0d act=%0d muted=%0d want all 0",
                  dacCount, busy_o, active_evt_o, muted_o);
      end
      nRst = 1'b1;
      tick(1);
      pulse_evt(3'b010);
      tick(2);
      checks++;
      if (busy_o !== 1'b1 || dacCount !== 8'd255) begin
         errors++;
         $display("FAIL reset_pre_note: busy=%0d dac=%0d want 1/255", busy_o, dacCount);
      end
      nRst = 1'b0;
      #1;
      checks++;
      if ({dacCount, busy_o, active_evt_o, muted_o} !== 12'h000) begin
         errors++;
         $display("FAIL reset_async_mid_note: dac=%0d busy=%0d act=%0d muted=%0d want all 0",
                  dacCount, busy_o, active_evt_o, muted_o);
      end
      tick(1);
      nRst = 1'b1;
      tick(1);
      pulse_btn();
      checks++;
      if (muted_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_mute: muted=%0d want 1", muted_o);
      end
      nRst = 1'b0;
      #1;
      checks++;
      if (muted_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_async_mute: muted=%0d want 0", muted_o);
      end
      tick(1);
      nRst = 1'b1;
      tick(1);
   endtask

   task automatic test_square();
      int first_zero;
      logic       exp_busy;
      logic [1:0] exp_act;
      logic [7:0] exp_dac;
      do_reset();
      set_cfg(16'd2, 16'd3, 16'd4, 24'd20, 24'd40, 24'd60, WAVE_SQUARE);
      pulse_evt(3'b100);
      checks++;
      if (busy_o !== 1'b1 || active_evt_o !== 2'd2 || dacCount !== 8'd0) begin
         errors++;
         $display("FAIL square_entry: busy=%0d act=%0d dac=%0d want 1/2/0",
                  busy_o, active_evt_o, dacCount);
      end
      for (int n = 1; n <= 61; n++) begin
         tick(1);
         exp_busy = (n < 60);
         exp_act  = (n < 60) ? 2'd2 : 2'd0;
         exp_dac  = (n <= 60) ? 8'd255 : 8'd0;
         checks++;
         if (busy_o !== exp_busy || active_evt_o !== exp_act || dacCount !== exp_dac) begin
            errors++;
            $display("FAIL square_cycle%0d: busy=%0d act=%0d dac=%0d want %0d/%0d/%0d",
                     n, busy_o, active_evt_o, dacCount, exp_busy, exp_act, exp_dac);
         end
      end
      do_reset();
      set_cfg(16'd2, 16'd3, 16'd4, 24'd20, 24'd40, 24'd1100, WAVE_SQUARE);
      pulse_evt(3'b100);
      first_zero = 0;
      for (int n = 1; n <= 600; n++) begin
         tick(1);
         if (first_zero == 0 && dacCount == 8'd0) first_zero = n;
      end
      checks++;
      if (first_zero != 513) begin
         errors++;
         $display("FAIL square_msb_edge: first zero at cycle %0d want 513", first_zero);
      end
   endtask

   task automatic test_sawtooth();
      logic [7:0] exp_dac;
      do_reset();
      set_cfg(16'd2, 16'd3, 16'd4, 24'd20, 24'd40, 24'd60, WAVE_SAW);
      pulse_evt(3'b001);
      for (int n = 1; n <= 21; n++) begin
         tick(1);
         exp_dac = (n <= 20) ? 8'((n - 1) / 2) : 8'd0;
         checks++;
         if (dacCount !== exp_dac || busy_o !== (n < 20)) begin
            errors++;
            $display("FAIL saw_cycle%0d: dac=%0d busy=%0d want %0d/%0d",
                     n, dacCount, busy_o, exp_dac, (n < 20));
         end
      end
   endtask

   task automatic test_priority();
      int len;
      do_reset();
      set_cfg(16'd2, 16'd3, 16'd4, 24'd20, 24'd40, 24'd60, WAVE_SQUARE);
      pulse_evt(3'b010);
      tick(5);
      pulse_evt(3'b100);
      tick(1);
      checks++;
      if (busy_o !== 1'b1 || active_evt_o !== 2'd1) begin
         errors++;
         $display("FAIL prio_low_ignored: busy=%0d act=%0d want 1/1", busy_o, active_evt_o);
      end
      pulse_evt(3'b001);
      checks++;
      if (busy_o !== 1'b1 || active_evt_o !== 2'd0) begin
         errors++;
         $display("FAIL prio_preempt: busy=%0d act=%0d want 1/0", busy_o, active_evt_o);
      end
      busy_len(len);
      checks++;
      if (len != 20) begin
         errors++;
         $display("FAIL prio_reload_len: len=%0d want 20", len);
      end
      tick(2);
      pulse_evt(3'b111);
      checks++;
      if (busy_o !== 1'b1 || active_evt_o !== 2'd0) begin
         errors++;
         $display("FAIL prio_all_three: busy=%0d act=%0d want 1/0", busy_o, active_evt_o);
      end
      busy_len(len);
      checks++;
      if (len != 20) begin
         errors++;
         $display("FAIL prio_all_three_len: len=%0d want 20", len);
      end
   endtask

   task automatic test_mute();
      do_reset();
      set_cfg(16'd2, 16'd3, 16'd4, 24'd20, 24'd40, 24'd60, WAVE_SQUARE);
      pulse_evt(3'b010);
      tick(3);
      pulse_btn();
      checks++;
      if (muted_o !== 1'b1 || busy_o !== 1'b0 || active_evt_o !== 2'd0) begin
         errors++;
         $display("FAIL mute_abort: muted=%0d busy=%0d act=%0d want 1/0/0",
                  muted_o, busy_o, active_evt_o);
      end
      tick(1);
      checks++;
      if (dacCount !== 8'd0) begin
         errors++;
         $display("FAIL mute_dac: dac=%0d want 0", dacCount);
      end
      pulse_evt(3'b001);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL mute_evt_ignored: busy=%0d want 0", busy_o);
      end
      tick(2);
      checks++;
      if (busy_o !== 1'b0 || dacCount !== 8'd0) begin
         errors++;
         $display("FAIL mute_no_queue: busy=%0d dac=%0d want 0/0", busy_o, dacCount);
      end
      pulse_btn();
      checks++;
      if (muted_o !== 1'b0) begin
         errors++;
         $display("FAIL unmute: muted=%0d want 0", muted_o);
      end
      tick(1);
      pulse_evt(3'b100);
      checks++;
      if (busy_o !== 1'b1 || active_evt_o !== 2'd2) begin
         errors++;
         $display("FAIL unmute_play: busy=%0d act=%0d want 1/2", busy_o, active_evt_o);
      end
      tick(3);
      req_if.button_i = 1'b1;
      req_if.evt_i    = 3'b001;
      tick(1);
      req_if.button_i = 1'b0;
      req_if.evt_i    = '0;
      checks++;
      if (muted_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL mute_beats_trigger: muted=%0d busy=%0d want 1/0", muted_o, busy_o);
      end
   endtask

   task automatic test_edge_cases();
      int len;
      do_reset();
      set_cfg(16'd2, 16'd0, 16'd4, 24'd0, 24'd20, 24'd20, WAVE_SAW);
      pulse_evt(3'b001);
      tick(1);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL dur_zero: busy=%0d want 0", busy_o);
      end
      pulse_evt(3'b010);
      for (int n = 1; n <= 20; n++) begin
         tick(1);
         checks++;
         if (dacCount !== 8'(n - 1)) begin
            errors++;
            $display("FAIL div_zero_cycle%0d: dac=%0d want %0d", n, dacCount, n - 1);
         end
      end
      tick(2);
      req_if.evt_i = 3'b100;
      tick(1);
      checks++;
      if (busy_o !== 1'b1 || active_evt_o !== 2'd2) begin
         errors++;
         $display("FAIL held_start: busy=%0d act=%0d want 1/2", busy_o, active_evt_o);
      end
      busy_len(len);
      checks++;
      if (len != 20) begin
         errors++;
         $display("FAIL held_len: len=%0d want 20", len);
      end
      for (int n = 0; n < 20; n++) begin
         tick(1);
         checks++;
         if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL held_refire: busy=%0d want 0 at cycle %0d", busy_o, n);
         end
      end
      req_if.evt_i = '0;
   endtask

   task automatic test_triangle();
      int p, t, expv, prev, diff;
      do_reset();
      set_cfg(16'd0, 16'd3, 16'd4, 24'd300, 24'd40, 24'd60, WAVE_TRI);
      pulse_evt(3'b001);
      prev = 0;
      for (int n = 1; n <= 260; n++) begin
         tick(1);
         p    = (n - 1) % 256;
         t    = (p * 2) % 256;
         expv = (p >= 128) ? 255 - t : t;
         checks++;
         if (int'(dacCount) != expv) begin
            errors++;
            $display("FAIL tri_cycle%0d: dac=%0d want %0d", n, dacCount, expv);
         end
         diff = int'(dacCount) - prev;
         if (diff < 0) diff = -diff;
         checks++;
         if (diff > 2) begin
            errors++;
            $display("FAIL tri_glitch%0d: step=%0d want <=2", n, diff);
         end
         prev = int'(dacCount);
         if (n == 129) begin
            checks++;
            if (dacCount !== 8'd255) begin
               errors++;
               $display("FAIL tri_peak: dac=%0d want 255", dacCount);
            end
         end
         if (n == 257) begin
            checks++;
            if (dacCount !== 8'd0) begin
               errors++;
               $display("FAIL tri_wrap: dac=%0d want 0", dacCount);
            end
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      nRst   = 1'b0;
      req_if.evt_i      = '0;
      req_if.button_i   = 1'b0;
      req_if.tone_div_i = '0;
      req_if.tone_dur_i = '0;
      req_if.wave_i     = 2'b00;
      test_reset();
      test_square();
      test_sawtooth();
      test_priority();
      test_mute();
      test_edge_cases();
      test_triangle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
